alu_mult_seq: RTL and testbench
===============================

# alu_mult_seq

Multi-cycle unsigned multiply sequencer for the EX stage. It runs MULTU as 32 shift-add iterations on the shared 32-bit ripple ALU, driving the ALU operand and control ports itself. It writes the 64-bit product to HI/LO. The pipeline stalls on `busy`, and the EX-stage operand mux hands the ALU to this block whenever `alu_req` is high.

## Interface
- `WIDTH`, 32: operand width; the iteration count equals `WIDTH`.
- `CTRL_ADD`, 4'b0010: ALU control code for add, taken from the shared package.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request a multiply. Accepted only in IDLE or DONE.
- `flush` in 1: pipeline flush. Aborts any operation in progress.
- `op_a` in WIDTH: multiplicand, sampled on accept.
- `op_b` in WIDTH: multiplier, sampled on accept.
- `busy` out 1: high while in RUN; the pipeline stall source.
- `done` out 1: one-cycle pulse; `hi`/`lo` are valid from this cycle.
- `hi` out WIDTH: upper product word; holds its value until the next accept.
- `lo` out WIDTH: lower product word; holds its value until the next accept.
- `alu_req` out 1: high in RUN; selects this block onto the ALU ports.
- `alu_a` out WIDTH: ALU operand A; equals the current `hi`.
- `alu_b` out WIDTH: ALU operand B; `lo[0] ? mcand : 0`.
- `alu_ctrl` out 4: always `CTRL_ADD`.
- `alu_result` in WIDTH: ALU sum, combinational return.
- `alu_carryout` in 1: ALU carry out of bit WIDTH-1.

## Operation
- States: IDLE, RUN, DONE. The state is encoded in a package enum.
- **IDLE/DONE + start (and not flush):**
  - latch `mcand <= op_a`, `lo <= op_b`, `hi <= 0`, `cnt <= 0`;
  - go to RUN.
- **DONE without start:** go to IDLE.
- **RUN, each cycle:**
  - `{hi, lo} <= {alu_carryout, alu_result, lo[WIDTH-1:1]}`;
  - `cnt <= cnt + 1`;
  - when `cnt == WIDTH-1`, go to DONE.
- Arithmetic is unsigned only. `cnt` is `$clog2(WIDTH)` bits wide and wraps to 0 on the final iteration. Carry is never lost: it becomes `hi[WIDTH-1]`.
- `start` in RUN is ignored. The requester must hold the instruction, which is stalled by `busy`.
- `flush` in any state returns to IDLE next cycle; `busy` and `done` drop. If `hi`/`lo` were mid-operation they are left partial and are architecturally undefined.
- `flush` and `start` in the same cycle: `flush` wins and nothing is accepted.
- `alu_carryout` and `alu_result` are used only in RUN. `alu_a`, `alu_b` and `alu_ctrl` may toggle freely outside RUN, because `alu_req` is low there.

## Timing
- Reset values: state = IDLE; `busy`=0, `done`=0, `alu_req`=0; `hi`=0, `lo`=0, `mcand`=0, `cnt`=0.
- Accept at edge 0. RUN occupies cycles 1..WIDTH (32 cycles). `done` is high in cycle WIDTH+1.
- Start-to-done latency is WIDTH+1 cycles.
- Back-to-back: `start` asserted during the DONE cycle is accepted. The next RUN begins the following cycle with no IDLE bubble, and `done` is not re-pulsed until that operation completes.
- The ALU path is combinational within one cycle: `hi` → `alu_a` → ripple ALU → `alu_result` → `hi`. The ALU ripple delay sets the RUN cycle limit.
- Reset asserted mid-operation clears all outputs asynchronously. No partial product is ever exposed with `done`=1.

## Structure
- Shared package `alu_pkg`:
  - ALU control codes: ADD 4'b0010, SUB 4'b0110, AND 4'b0000, OR 4'b0001, SLT 4'b0111;
  - state enum `mult_state_t`.
- The ALU is not instantiated inside this block. The EX-stage top muxes ALU inputs on `alu_req`, so the single ALU serves both ordinary ops and MULTU.
- No sub-module is needed. A single FSM plus datapath registers is sufficient.
- The bench instantiates this block wired to the real 32-bit ALU.

## Test plan
- **Basic:** `op_a`=3, `op_b`=5, `start` → `busy` for 32 cycles; `done` at cycle 33 with `hi`=0, `lo`=15.
- **Maximum operands:** `op_a`=`op_b`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. Exercises carry into `hi[31]`.
- **Zero and large:** `op_a`=0x80000000, `op_b`=2 → `hi`=1, `lo`=0. Then `op_a`=0, `op_b`=0xDEADBEEF → `hi`=`lo`=0.
- **Start while busy:** pulse `start` with new operands at cycle 10 → ignored; the first product completes unchanged at cycle 33. Then `start` in the DONE cycle → second `done` exactly 33 cycles later.
- **Flush:** `flush` at cycle 15 → IDLE next cycle, `busy`=0, no `done`. `flush`+`start` together → not accepted.
- **Reset:** `rst_n` low at cycle 20 → all outputs 0 immediately. After release, a fresh 7×6 gives `lo`=42 at the normal latency.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes and multiply sequencer state encoding
package alu_pkg;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_RUN  = 2'd1,
        MULT_DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/alu_32.sv
// rtl/alu_32.sv - shared 32-bit ripple ALU (and/or/add/sub/slt)
module alu_32
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  ctrl,
    output logic [31:0] result,
    output logic        carryout,
    output logic        zero
);

    logic        sub_mode;
    logic [31:0] b_eff;
    logic [31:0] sum;
    logic        c;
    logic        ovf;

    assign sub_mode = (ctrl == CTRL_SUB) || (ctrl == CTRL_SLT);
    assign b_eff    = sub_mode ? ~b : b;

    // Bit-serial carry chain so the critical path matches the physical ripple adder.
    always_comb begin
        sum = '0;
        c   = sub_mode;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b_eff[i] ^ c;
            c      = (a[i] & b_eff[i]) | (a[i] & c) | (b_eff[i] & c);
        end
    end

    assign carryout = c;
    assign ovf      = (a[31] ^ b_eff[31] ^ 1'b1) & (a[31] ^ sum[31]);

    always_comb begin
        result = '0;
        case (ctrl)
            CTRL_AND: result = a & b;
            CTRL_OR:  result = a | b;
            CTRL_ADD: result = sum;
            CTRL_SUB: result = sum;
            CTRL_SLT: result = {31'b0, sum[31] ^ ovf};
            default:  result = '0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/alu_mult_seq.sv
// rtl/alu_mult_seq.sv - unsigned shift-add MULTU sequencer borrowing the shared ALU
module alu_mult_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             alu_req,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mult_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MULT_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        if (flush) begin
            // Flush beats a simultaneous start; partial hi/lo are left as-is.
            state_d = MULT_IDLE;
        end else begin
            case (state_q)
                MULT_IDLE, MULT_DONE: begin
                    if (start) begin
                        mcand_d = op_a;
                        lo_d    = op_b;
                        hi_d    = '0;
                        cnt_d   = '0;
                        state_d = MULT_RUN;
                    end else begin
                        state_d = MULT_IDLE;
                    end
                end
                MULT_RUN: begin
                    // Carry out of the add lands in hi[MSB]; multiplier bits shift out of lo.
                    {hi_d, lo_d} = {alu_carryout, alu_result, lo_q[WIDTH-1:1]};
                    cnt_d        = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = MULT_DONE;
                    end
                end
                default: state_d = MULT_IDLE;
            endcase
        end
    end

    assign busy     = (state_q == MULT_RUN);
    assign done     = (state_q == MULT_DONE);
    assign alu_req  = busy;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign alu_a    = hi_q;
    assign alu_b    = lo_q[0] ? mcand_q : '0;
    assign alu_ctrl = CTRL_ADD;

endmodule

// File: tb/tb_alu_mult_seq.sv
// tb/tb_alu_mult_seq.sv - directed self-checking bench for alu_mult_seq on the real ALU
module tb_alu_mult_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        alu_req;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_carryout;
    logic        alu_zero;

    int checks;
    int errors;

    alu_mult_seq #(.WIDTH(32)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .flush        (flush),
        .op_a         (op_a),
        .op_b         (op_b),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo),
        .alu_req      (alu_req),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout)
    );

    alu_32 u_alu (
        .a        (alu_a),
        .b        (alu_b),
        .ctrl     (alu_ctrl),
        .result   (alu_result),
        .carryout (alu_carryout),
        .zero     (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles from the accept edge until done, bounded.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 1;
        busy_cycles = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cycles++;
            tick();
            lat++;
        end
    endtask

    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        int bc;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
        wait_done(lat, bc);
        check({tag, "_lat"}, 64'(lat), 64'd33);
        check({tag, "_busycyc"}, 64'(bc), 64'd32);
        check({tag, "_prod"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        int lat;
        int bc;
        int seen_done;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        op_a   = '0;
        op_b   = '0;
        #12;
        check("rst_outs", {58'd0, busy, done, alu_req, 3'd0}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        tick();
        check("alu_ctrl", 64'(alu_ctrl), 64'h2);

        run_mult("basic", 32'd3, 32'd5, 32'd0, 32'd15);
        tick();
        check("done_pulse", {63'd0, done}, 64'd0);
        run_mult("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        tick();
        run_mult("big", 32'h8000_0000, 32'd2, 32'd1, 32'd0);
        tick();
        run_mult("zero", 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0);
        tick();

        // Start while busy is ignored, then back-to-back start in the DONE cycle.
        op_a  = 32'h1234_5678;
        op_b  = 32'h10;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        op_a  = 32'd99;
        op_b  = 32'd77;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_busy", {63'd0, busy}, 64'd1);
        lat = 11;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        check("ign_lat", 64'(lat), 64'd33);
        check("ign_prod", {hi, lo}, 64'h1_2345_6780);
        op_a  = 32'd7;
        op_b  = 32'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_nodone", {62'd0, busy, done}, 64'b10);
        wait_done(lat, bc);
        check("b2b_lat", 64'(lat), 64'd33);
        check("b2b_prod", {hi, lo}, 64'd63);
        tick();

        // Flush mid-run.
        op_a  = 32'd3;
        op_b  = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_idle", {62'd0, busy, done}, 64'd0);
        seen_done = 0;
        repeat (25) begin
            if (done || busy) seen_done++;
            tick();
        end
        check("flush_nodone", 64'(seen_done), 64'd0);
        flush = 1'b1;
        start = 1'b1;
        tick();
        flush = 1'b0;
        start = 1'b0;
        check("flush_start", {62'd0, busy, done}, 64'd0);
        tick();
        check("flush_start2", {62'd0, busy, done}, 64'd0);

        // Asynchronous reset mid-run.
        op_a  = 32'd5;
        op_b  = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ctrl", {61'd0, busy, done, alu_req}, 64'd0);
        check("arst_hilo", {hi, lo}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_mult("post_rst", 32'd7, 32'd6, 32'd0, 32'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
